cpu_cg: RTL and testbench



---
 rtl/cpu_cg_pkg.sv | 51 +++++
 rtl/cpu_cg_if.sv | 14 +
 rtl/cpu_cg_popcount.sv | 16 +
 rtl/cpu_cg.sv | 51 +++++
 tb/tb_cpu_cg.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/cpu_cg_pkg.sv
// Shared types and bin-layout constants for the CPU instruction-stream coverage collector.
// The bitmap is packed low to high as instr, mode, resource, addr quadrant, then instr x mode cross.
package cpu_cg_pkg;

  typedef enum logic [2:0] {
    INSTR_NOP   = 3'd0,
    INSTR_LOAD  = 3'd1,
    INSTR_STORE = 3'd2,
    INSTR_ADD   = 3'd3,
    INSTR_SUB   = 3'd4,
    INSTR_AND   = 3'd5,
    INSTR_OR    = 3'd6,
    INSTR_JMP   = 3'd7
  } instr_e;

  typedef enum logic [1:0] {
    MODE_FETCH     = 2'd0,
    MODE_DECODE    = 2'd1,
    MODE_EXECUTE   = 2'd2,
    MODE_WRITEBACK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    RES_REG = 2'd0,
    RES_MEM = 2'd1,
    RES_IO  = 2'd2,
    RES_ALU = 2'd3
  } resource_e;

  localparam int NUM_INSTR_BINS = 8;
  localparam int NUM_MODE_BINS  = 4;
  localparam int NUM_RES_BINS   = 4;
  localparam int NUM_ADDR_BINS  = 4;
  localparam int NUM_CROSS_BINS = 32;
  localparam int NUM_BINS       = NUM_INSTR_BINS + NUM_MODE_BINS + NUM_RES_BINS
                                + NUM_ADDR_BINS + NUM_CROSS_BINS;

  localparam int COUNT_W = 6;

  typedef logic [NUM_BINS-1:0] bitmap_t;

  // Exact floor(count*100/52); product fits in 13 bits for count <= 63.
  function automatic logic [7:0] pct_of(input logic [COUNT_W-1:0] count);
    logic [12:0] prod;
    logic [12:0] quot;
    prod = 13'(count) * 13'd100;
    quot = prod / 13'(NUM_BINS);
    return quot[7:0];
  endfunction

endpackage

// File: rtl/cpu_cg_if.sv
// Sampled CPU instruction-stream signals plus the coverage score returned by the collector.
interface cpu_cg_if;
  import cpu_cg_pkg::*;

  logic [15:0] addr;
  instr_e      instr;
  mode_e       mode;
  resource_e   resource;
  logic [15:0] data;

  modport master (output addr, output instr, output mode, output resource, input data);
  modport slave  (input addr, input instr, input mode, input resource, output data);

endinterface

// File: rtl/cpu_cg_popcount.sv
// Combinational population count of the coverage bitmap.
module cg_popcount
  import cpu_cg_pkg::*;
(
  input  bitmap_t            bits,
  output logic [COUNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_BINS; i++) begin
      count = count + COUNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/cpu_cg.sv
// Passive functional-coverage collector: sticky hit bitmap over five bin groups,
// reporting {covered count, percentage} one cycle after each sample.
module cpu_cg
  import cpu_cg_pkg::*;
(
  input logic       clk,
  input logic       rst,
  cpu_cg_if.slave   bus
);

  bitmap_t                bitmap_q;
  bitmap_t                bitmap_d;
  bitmap_t                hit;
  logic [COUNT_W-1:0]     count;
  logic [15:0]            data_q;

  logic [NUM_INSTR_BINS-1:0] instr_hit;
  logic [NUM_MODE_BINS-1:0]  mode_hit;
  logic [NUM_RES_BINS-1:0]   res_hit;
  logic [NUM_ADDR_BINS-1:0]  addr_hit;
  logic [NUM_CROSS_BINS-1:0] cross_hit;

  // One-hot per group; cross index is {instr, mode}.
  always_comb begin
    instr_hit = NUM_INSTR_BINS'(1) << bus.instr;
    mode_hit  = NUM_MODE_BINS'(1)  << bus.mode;
    res_hit   = NUM_RES_BINS'(1)   << bus.resource;
    addr_hit  = NUM_ADDR_BINS'(1)  << bus.addr[15:14];
    cross_hit = NUM_CROSS_BINS'(1) << {bus.instr, bus.mode};
    hit       = {cross_hit, addr_hit, res_hit, mode_hit, instr_hit};
    bitmap_d  = bitmap_q | hit;
  end

  cg_popcount u_popcount (
    .bits  (bitmap_d),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q <= '0;
      data_q   <= '0;
    end else begin
      bitmap_q <= bitmap_d;
      data_q   <= {2'b00, count, pct_of(count)};
    end
  end

  assign bus.data = data_q;

endmodule

// File: tb/tb_cpu_cg.sv
// Self-checking bench for cpu_cg: table vectors, a full sweep and a random run, scored against a bin model.
module tb_cpu_cg;
  import cpu_cg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_cg_if bus();

  cpu_cg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_q[$];

  // Reference model: separate seen-flags per group, counted independently.
  bit m_instr[8];
  bit m_mode[4];
  bit m_res[4];
  bit m_quad[4];
  bit m_cross[8][4];

  typedef struct {
    logic        r;
    instr_e      instr;
    mode_e       mode;
    resource_e   res;
    logic [15:0] addr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_instr[i] = 0;
      for (int j = 0; j < 4; j++) m_cross[i][j] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0;
      m_res[i]  = 0;
      m_quad[i] = 0;
    end
  endfunction

  function automatic logic [15:0] model_step(input logic r, input instr_e i, input mode_e m,
                                             input resource_e s, input logic [15:0] a);
    int cnt;
    int pct;
    if (r) begin
      model_clear();
      return 16'h0000;
    end
    m_instr[int'(i)] = 1;
    m_mode[int'(m)]  = 1;
    m_res[int'(s)]   = 1;
    m_quad[int'(a) / 16384] = 1;
    m_cross[int'(i)][int'(m)] = 1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cnt += int'(m_instr[k]);
      for (int j = 0; j < 4; j++) cnt += int'(m_cross[k][j]);
    end
    for (int k = 0; k < 4; k++) cnt += int'(m_mode[k]) + int'(m_res[k]) + int'(m_quad[k]);
    pct = (cnt * 100) / 52;
    return {8'(cnt), 8'(pct)};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, got, exp);
  endtask

  task automatic step(input logic r, input instr_e i, input mode_e m, input resource_e s,
                      input logic [15:0] a, input string name, output logic [15:0] got);
    rst          = r;
    bus.instr    = i;
    bus.mode     = m;
    bus.resource = s;
    bus.addr     = a;
    exp_q.push_back(model_step(r, i, m, s, a));
    @(posedge clk);
    #1;
    got = bus.data;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got 0x%04h", name, got);
    end else begin
      check(name, got, exp_q.pop_front());
    end
  endtask

  logic [15:0] got;

  initial begin
    model_clear();
    rst          = 1'b1;
    bus.instr    = INSTR_SUB;
    bus.mode     = MODE_WRITEBACK;
    bus.resource = RES_ALU;
    bus.addr     = 16'hBEEF;

    vecs[0] = '{1'b1, INSTR_OR,   MODE_DECODE,  RES_IO,  16'h7777, 16'h0000};
    vecs[1] = '{1'b1, INSTR_LOAD, MODE_FETCH,   RES_MEM, 16'hFFFF, 16'h0000};
    vecs[2] = '{1'b0, INSTR_ADD,  MODE_EXECUTE, RES_MEM, 16'h1234, 16'h0509};
    vecs[3] = '{1'b0, INSTR_ADD,  MODE_EXECUTE, RES_MEM, 16'h1234, 16'h0509};
    vecs[4] = '{1'b0, INSTR_ADD,  MODE_EXECUTE, RES_MEM, 16'h1234, 16'h0509};
    vecs[5] = '{1'b0, INSTR_ADD,  MODE_EXECUTE, RES_MEM, 16'h1234, 16'h0509};
    vecs[6] = '{1'b0, INSTR_JMP,  MODE_FETCH,   RES_IO,  16'hC000, 16'h0A13};
    // Same quadrant/resource, new instr+mode+cross: adds 3.
    vecs[7] = '{1'b0, INSTR_SUB,  MODE_DECODE,  RES_IO,  16'hC001, 16'h0D19};
    // Only a new cross bin (ADD x FETCH): adds 1.
    vecs[8] = '{1'b0, INSTR_ADD,  MODE_FETCH,   RES_MEM, 16'h0000, 16'h0E1A};

    for (int v = 0; v < 9; v++) begin
      step(vecs[v].r, vecs[v].instr, vecs[v].mode, vecs[v].res, vecs[v].addr, "table", got);
      check("table_const", got, vecs[v].exp);
    end

    for (int k = 0; k < 32; k++) begin
      step(1'b0, instr_e'(3'(k / 4)), mode_e'(2'(k % 4)), resource_e'(2'(k % 4)),
           16'((k % 4) * 16384 + k), "sweep", got);
    end
    check("full_cov", got, 16'h3464);
    step(1'b0, INSTR_NOP, MODE_FETCH, RES_REG, 16'h0042, "post_full", got);
    check("full_hold", got, 16'h3464);

    step(1'b1, INSTR_JMP, MODE_WRITEBACK, RES_ALU, 16'hFFFF, "rst_full", got);
    check("rst_clear", got, 16'h0000);
    step(1'b0, INSTR_NOP, MODE_DECODE, RES_REG, 16'h8000, "after_rst", got);
    check("after_rst_const", got, 16'h0509);

    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 39) == 0), instr_e'(3'($urandom_range(0, 7))),
           mode_e'(2'($urandom_range(0, 3))), resource_e'(2'($urandom_range(0, 3))),
           16'($urandom), "random", got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
